// File: rtl/ultra_echo_responder.sv
// Emulates an ultrasonic ranging sensor: a valid trigger pulse from the peripheral under test
// is answered after a fixed burst delay by an echo pulse whose width encodes the programmed distance.
module ultra_echo_responder #(
   parameter int T_TRIG_MIN = 500,
   parameter int T_BURST    = 23000,
   parameter int CYC_PER_CM = 2900,
   parameter int T_TIMEOUT  = 1900000,
   parameter int T_HOLDOFF  = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] d_in,
   input  logic        cs,
   input  logic [1:0]  addr,
   input  logic        rd,
   input  logic        wr,
   output logic [15:0] d_out,
   input  logic        trigg,
   output logic        echo
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      TRIG  = 3'd1,
      BURST = 3'd2,
      ECHO  = 3'd3,
      HOLD  = 3'd4
   } state_t;

   state_t      state_reg, state_next;
   logic [31:0] cnt_reg, cnt_next;
   logic [31:0] width_reg, width_next;
   logic        echo_reg, echo_next;
   logic [15:0] dist_reg;
   logic        en_reg;
   logic [7:0]  trig_cnt_reg;
   logic [15:0] err_cnt_reg;
   logic [15:0] d_out_reg;
   logic [2:0]  sync_reg;
   logic        trig_s, trig_rise;
   logic        trig_ok, trig_short;
   logic [31:0] dist_cycles;
   logic        dist_in_range;
   logic [2:0]  state_bits;
   logic [15:0] rd_data;

   // Stages 0 and 1 synchronise trigg; stage 2 is the previous synchronised value for edge detection.
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_sync
         if (gi == 0) begin : g_first
            always_ff @(posedge clk) begin
               if (rst) sync_reg[gi] <= 1'b0;
               else     sync_reg[gi] <= trigg;
            end
         end else begin : g_rest
            always_ff @(posedge clk) begin
               if (rst) sync_reg[gi] <= 1'b0;
               else     sync_reg[gi] <= sync_reg[gi-1];
            end
         end
      end
   endgenerate

   assign trig_s        = sync_reg[1];
   assign trig_rise     = sync_reg[1] & ~sync_reg[2];
   assign dist_cycles   = 32'(dist_reg) * 32'(CYC_PER_CM);
   assign dist_in_range = (dist_reg >= 16'd2) && (dist_reg <= 16'd400);

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      width_next = width_reg;
      echo_next  = echo_reg;
      trig_ok    = 1'b0;
      trig_short = 1'b0;
      case (state_reg)
         IDLE: begin
            // The edge-detect cycle is already the first high cycle of the pulse.
            if (trig_rise && en_reg) begin
               state_next = TRIG;
               cnt_next   = 32'd1;
            end
         end
         TRIG: begin
            if (trig_s) begin
               if (cnt_reg != 32'hFFFF_FFFF) cnt_next = cnt_reg + 32'd1;
            end else if (cnt_reg >= 32'(T_TRIG_MIN)) begin
               state_next = BURST;
               cnt_next   = 32'd0;
               width_next = dist_in_range ? dist_cycles : 32'(T_TIMEOUT);
               trig_ok    = 1'b1;
            end else begin
               state_next = IDLE;
               cnt_next   = 32'd0;
               trig_short = 1'b1;
            end
         end
         BURST: begin
            if (cnt_reg == 32'(T_BURST - 1)) begin
               state_next = ECHO;
               cnt_next   = 32'd0;
               echo_next  = 1'b1;
            end else begin
               cnt_next = cnt_reg + 32'd1;
            end
         end
         ECHO: begin
            if (cnt_reg == width_reg - 32'd1) begin
               state_next = HOLD;
               cnt_next   = 32'd0;
               echo_next  = 1'b0;
            end else begin
               cnt_next = cnt_reg + 32'd1;
            end
         end
         HOLD: begin
            if (cnt_reg == 32'(T_HOLDOFF - 1)) begin
               state_next = IDLE;
               cnt_next   = 32'd0;
            end else begin
               cnt_next = cnt_reg + 32'd1;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = 32'd0;
            echo_next  = 1'b0;
         end
      endcase
   end

   assign state_bits = state_reg;

   always_comb begin
      rd_data = 16'h0000;
      case (addr)
         2'd0: rd_data = dist_reg;
         2'd1: rd_data = {15'd0, en_reg};
         2'd2: rd_data = {trig_cnt_reg, 4'b0000, state_bits, (state_reg != IDLE)};
         2'd3: rd_data = err_cnt_reg;
         default: rd_data = 16'h0000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         cnt_reg      <= 32'd0;
         width_reg    <= 32'd0;
         echo_reg     <= 1'b0;
         dist_reg     <= 16'd0;
         en_reg       <= 1'b0;
         trig_cnt_reg <= 8'd0;
         err_cnt_reg  <= 16'd0;
         d_out_reg    <= 16'd0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         width_reg <= width_next;
         echo_reg  <= echo_next;
         if (trig_ok) trig_cnt_reg <= trig_cnt_reg + 8'd1;
         if (trig_short && (err_cnt_reg != 16'hFFFF)) err_cnt_reg <= err_cnt_reg + 16'd1;
         // A combined read+write strobe is treated as a write only.
         if (cs && wr) begin
            case (addr)
               2'd0: dist_reg <= d_in;
               2'd1: en_reg   <= d_in[0];
               default: ;
            endcase
         end else if (cs && rd) begin
            d_out_reg <= rd_data;
         end
      end
   end

   assign d_out = d_out_reg;
   assign echo  = echo_reg;

endmodule

// File: tb/tb_ultra_echo_responder.sv
// Randomised bench for ultra_echo_responder with a behavioural register/echo model;
// timing parameters are scaled down so every scenario fits a short run.
module tb_ultra_echo_responder;

   localparam int T_TRIG_MIN = 20;
   localparam int T_BURST    = 60;
   localparam int CYC_PER_CM = 5;
   localparam int T_TIMEOUT  = 2500;
   localparam int T_HOLDOFF  = 40;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] d_in = 16'd0;
   logic        cs = 1'b0;
   logic [1:0]  addr = 2'd0;
   logic        rd = 1'b0;
   logic        wr = 1'b0;
   logic [15:0] d_out;
   logic        trigg = 1'b0;
   logic        echo;

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural model of the visible register state
   int         m_dist;
   bit         m_en;
   logic [7:0] m_trig;
   int         m_err;

   bit          got;
   int          dly, wid;
   logic [15:0] q;

   ultra_echo_responder #(
      .T_TRIG_MIN(T_TRIG_MIN), .T_BURST(T_BURST), .CYC_PER_CM(CYC_PER_CM),
      .T_TIMEOUT(T_TIMEOUT), .T_HOLDOFF(T_HOLDOFF)
   ) dut (
      .clk(clk), .rst(rst), .d_in(d_in), .cs(cs), .addr(addr), .rd(rd), .wr(wr),
      .d_out(d_out), .trigg(trigg), .echo(echo)
   );

   always #5 clk = ~clk;

   function automatic int exp_width(input int d);
      if (d >= 2 && d <= 400) return d * CYC_PER_CM;
      return T_TIMEOUT;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
      cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = a; d_in = d;
      tick();
      cs = 1'b0; wr = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [15:0] r);
      cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = a;
      tick();
      cs = 1'b0; rd = 1'b0;
      r = d_out;
   endtask

   // Drives a trigger pulse, then measures echo delay (from trigg fall) and width, then waits out the holdoff.
   task automatic run_trigger(input int hi, output bit g, output int dl, output int wd);
      trigg = 1'b1;
      repeat (hi) tick();
      trigg = 1'b0;
      g = 1'b0; dl = 0; wd = 0;
      for (int k = 1; k <= T_BURST + 10; k++) begin
         tick();
         if (echo === 1'b1) begin g = 1'b1; dl = k; break; end
      end
      if (g) begin
         while (echo === 1'b1 && wd < T_TIMEOUT + 50) begin tick(); wd++; end
      end
      repeat (T_HOLDOFF + 5) tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      m_dist = 0; m_en = 1'b0; m_trig = 8'd0; m_err = 0;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (echo !== 1'b0) begin n_bad++; $display("FAIL reset_echo: got %b want 0", echo); end
      n_cmp++; if (d_out !== 16'h0) begin n_bad++; $display("FAIL reset_dout: got %h want 0000", d_out); end
      for (int a = 0; a < 4; a++) begin
         bus_read(2'(a), q);
         n_cmp++; if (q !== 16'h0) begin n_bad++; $display("FAIL reset_reg%0d: got %h want 0000", a, q); end
      end
      $display("reset: registers read back after reset");
   endtask

   task automatic test_disabled();
      bus_write(2'd0, 16'd35); m_dist = 35;
      run_trigger(T_TRIG_MIN + 10, got, dly, wid);
      n_cmp++; if (got !== 1'b0) begin n_bad++; $display("FAIL disabled_echo: got %b want 0", got); end
      bus_read(2'd2, q);
      n_cmp++; if (q !== {m_trig, 8'h00}) begin n_bad++; $display("FAIL disabled_status: got %h want %h", q, {m_trig, 8'h00}); end
      $display("disabled: trigger with enable=0, echo=%b", got);
   endtask

   task automatic test_basic();
      bus_write(2'd1, 16'd1); m_en = 1'b1;
      bus_write(2'd0, 16'd35); m_dist = 35;
      bus_read(2'd0, q);
      n_cmp++; if (q !== 16'd35) begin n_bad++; $display("FAIL basic_dist_rd: got %0d want 35", q); end
      run_trigger(T_TRIG_MIN + 10, got, dly, wid);
      m_trig++;
      n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL basic_echo: got %b want 1", got); end
      n_cmp++; if (!(dly >= T_BURST + 2 && dly <= T_BURST + 3)) begin
         n_bad++; $display("FAIL basic_delay: got %0d want %0d..%0d", dly, T_BURST + 2, T_BURST + 3);
      end
      n_cmp++; if (wid !== exp_width(35)) begin n_bad++; $display("FAIL basic_width: got %0d want %0d", wid, exp_width(35)); end
      $display("basic: dist=35 delay=%0d width=%0d", dly, wid);
   endtask

   task automatic test_range();
      int dl[6];
      dl = '{500, 0, 1, 401, 2, 400};
      for (int i = 0; i < 6; i++) begin
         bus_write(2'd0, 16'(dl[i])); m_dist = dl[i];
         run_trigger(T_TRIG_MIN + 3, got, dly, wid);
         m_trig++;
         n_cmp++; if (wid !== exp_width(dl[i])) begin
            n_bad++; $display("FAIL range_width_d%0d: got %0d want %0d", dl[i], wid, exp_width(dl[i]));
         end
         $display("range: dist=%0d width=%0d", dl[i], wid);
      end
   endtask

   task automatic test_short();
      int hs[3];
      hs = '{T_TRIG_MIN - 1, 5, T_TRIG_MIN};
      for (int i = 0; i < 3; i++) begin
         run_trigger(hs[i], got, dly, wid);
         if (hs[i] >= T_TRIG_MIN) m_trig++; else m_err++;
         n_cmp++; if (got !== (hs[i] >= T_TRIG_MIN)) begin
            n_bad++; $display("FAIL short_echo_h%0d: got %b want %b", hs[i], got, hs[i] >= T_TRIG_MIN);
         end
         bus_read(2'd3, q);
         n_cmp++; if (q !== 16'(m_err)) begin n_bad++; $display("FAIL short_errcnt_h%0d: got %0d want %0d", hs[i], q, m_err); end
         bus_read(2'd2, q);
         n_cmp++; if (q[15:8] !== m_trig) begin n_bad++; $display("FAIL short_trigcnt_h%0d: got %0d want %0d", hs[i], q[15:8], m_trig); end
         $display("short: high=%0d echo=%b errcnt=%0d", hs[i], got, m_err);
      end
   endtask

   task automatic test_random();
      int d, hi;
      bit valid;
      for (int i = 0; i < 8; i++) begin
         d = int'($urandom_range(0, 450));
         valid = ($urandom_range(0, 3) != 0);
         hi = valid ? int'($urandom_range(T_TRIG_MIN, T_TRIG_MIN + 40)) : int'($urandom_range(1, T_TRIG_MIN - 1));
         bus_write(2'd0, 16'(d)); m_dist = d;
         run_trigger(hi, got, dly, wid);
         if (valid) m_trig++; else m_err++;
         n_cmp++; if (got !== valid) begin n_bad++; $display("FAIL rand%0d_echo: got %b want %b", i, got, valid); end
         if (valid) begin
            n_cmp++; if (wid !== exp_width(d)) begin n_bad++; $display("FAIL rand%0d_width: got %0d want %0d", i, wid, exp_width(d)); end
         end
         bus_read(2'd3, q);
         n_cmp++; if (q !== 16'(m_err)) begin n_bad++; $display("FAIL rand%0d_errcnt: got %0d want %0d", i, q, m_err); end
         bus_read(2'd2, q);
         n_cmp++; if (q !== {m_trig, 8'h00}) begin n_bad++; $display("FAIL rand%0d_status: got %h want %h", i, q, {m_trig, 8'h00}); end
         $display("random %0d: dist=%0d high=%0d echo=%b width=%0d", i, d, hi, got, wid);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] st;
      bit          seen;
      st = 16'h0;
      bus_write(2'd0, 16'd30); m_dist = 30;
      trigg = 1'b1;
      repeat (T_TRIG_MIN + 5) tick();
      trigg = 1'b0;
      m_trig++;
      got = 1'b0;
      for (int k = 1; k <= T_BURST + 10; k++) begin
         tick();
         if (echo === 1'b1) begin got = 1'b1; break; end
      end
      wid = 0;
      // While echo is high: a second valid trigger, a STATUS read and a DIST write for the next run.
      while (got && echo === 1'b1 && wid < T_TIMEOUT + 50) begin
         if (wid == 5)                  trigg = 1'b1;
         if (wid == 10 + T_TRIG_MIN)    trigg = 1'b0;
         if (wid == 40) begin cs = 1'b1; rd = 1'b1; addr = 2'd2; end
         if (wid == 41) begin cs = 1'b0; rd = 1'b0; st = d_out; end
         if (wid == 60) begin cs = 1'b1; wr = 1'b1; addr = 2'd0; d_in = 16'd10; end
         if (wid == 61) begin cs = 1'b0; wr = 1'b0; end
         tick();
         wid++;
      end
      m_dist = 10;
      n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL b2b_echo: got %b want 1", got); end
      n_cmp++; if (wid !== exp_width(30)) begin n_bad++; $display("FAIL b2b_width: got %0d want %0d", wid, exp_width(30)); end
      n_cmp++; if (st[0] !== 1'b1) begin n_bad++; $display("FAIL b2b_busy: got %b want 1", st[0]); end
      // Trigger inside the holdoff window must be ignored.
      trigg = 1'b1;
      repeat (T_TRIG_MIN + 5) tick();
      trigg = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < T_HOLDOFF + T_BURST + 20; k++) begin
         tick();
         if (echo === 1'b1) seen = 1'b1;
      end
      n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL b2b_hold_echo: got %b want 0", seen); end
      bus_read(2'd2, q);
      n_cmp++; if (q !== {m_trig, 8'h00}) begin n_bad++; $display("FAIL b2b_status: got %h want %h", q, {m_trig, 8'h00}); end
      bus_read(2'd3, q);
      n_cmp++; if (q !== 16'(m_err)) begin n_bad++; $display("FAIL b2b_errcnt: got %0d want %0d", q, m_err); end
      run_trigger(T_TRIG_MIN + 5, got, dly, wid);
      m_trig++;
      n_cmp++; if (wid !== exp_width(m_dist)) begin n_bad++; $display("FAIL b2b_next_width: got %0d want %0d", wid, exp_width(m_dist)); end
      $display("back_to_back: status=%h next width=%0d", st, wid);
   endtask

   task automatic test_rdwr();
      bus_read(2'd1, q);
      n_cmp++; if (q !== {15'd0, m_en}) begin n_bad++; $display("FAIL rdwr_ctrl: got %h want %h", q, {15'd0, m_en}); end
      cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = 2'd0; d_in = 16'd77;
      tick();
      cs = 1'b0; rd = 1'b0; wr = 1'b0;
      m_dist = 77;
      n_cmp++; if (d_out !== {15'd0, m_en}) begin n_bad++; $display("FAIL rdwr_hold: got %h want %h", d_out, {15'd0, m_en}); end
      bus_write(2'd3, 16'h1234);
      bus_read(2'd0, q);
      n_cmp++; if (q !== 16'd77) begin n_bad++; $display("FAIL rdwr_dist: got %0d want 77", q); end
      bus_read(2'd3, q);
      n_cmp++; if (q !== 16'(m_err)) begin n_bad++; $display("FAIL rdwr_errcnt_ro: got %0d want %0d", q, m_err); end
      $display("rdwr: combined strobe wrote dist=77");
   endtask

   task automatic test_reset_mid_echo();
      bus_write(2'd0, 16'd100); m_dist = 100;
      trigg = 1'b1;
      repeat (T_TRIG_MIN + 5) tick();
      trigg = 1'b0;
      got = 1'b0;
      for (int k = 1; k <= T_BURST + 10; k++) begin
         tick();
         if (echo === 1'b1) begin got = 1'b1; break; end
      end
      repeat (20) tick();
      n_cmp++; if (echo !== 1'b1) begin n_bad++; $display("FAIL midreset_pre: got %b want 1", echo); end
      rst = 1'b1;
      tick();
      n_cmp++; if (echo !== 1'b0) begin n_bad++; $display("FAIL midreset_echo: got %b want 0", echo); end
      rst = 1'b0;
      m_dist = 0; m_en = 1'b0; m_trig = 8'd0; m_err = 0;
      bus_read(2'd2, q);
      n_cmp++; if (q !== 16'h0) begin n_bad++; $display("FAIL midreset_status: got %h want 0000", q); end
      bus_read(2'd0, q);
      n_cmp++; if (q !== 16'h0) begin n_bad++; $display("FAIL midreset_dist: got %h want 0000", q); end
      bus_write(2'd0, 16'd20); m_dist = 20;
      run_trigger(T_TRIG_MIN + 5, got, dly, wid);
      n_cmp++; if (got !== 1'b0) begin n_bad++; $display("FAIL midreset_disabled: got %b want 0", got); end
      $display("reset_mid_echo: echo cleared, enable required afterwards");
   endtask

   initial begin
      test_reset();
      test_disabled();
      test_basic();
      test_range();
      test_short();
      test_random();
      test_back_to_back();
      test_rdwr();
      test_reset_mid_echo();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ultra_echo_responder.md
ULTRA_ECHO_RESPONDER -- requirements
Module: ultra_echo_responder

Interface
REQ-001 Parameter T_TRIG_MIN, default 500, minimum trigg high width in clk cycles for a valid trigger (10 us at 50 MHz).
REQ-002 Parameter T_BURST, default 23000, delay in cycles from trigg fall to echo rise (460 us, 8-pulse burst time).
REQ-003 Parameter CYC_PER_CM, default 2900, echo high cycles per programmed cm (58 us/cm).
REQ-004 Parameter T_TIMEOUT, default 1900000, echo width in cycles for out-of-range distance (38 ms).
REQ-005 Parameter T_HOLDOFF, default 50000, cycles after echo fall during which trigg is ignored.
REQ-006 clk  input  1  system clock; all logic on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 d_in  input  16  bus write data.
REQ-009 cs  input  1  chip select; bus access only when high.
REQ-010 addr  input  2  register address.
REQ-011 rd  input  1  read strobe.
REQ-012 wr  input  1  write strobe.
REQ-013 d_out  output  16  registered read data.
REQ-014 trigg  input  1  trigger from the ultrasonic peripheral under test.
REQ-015 echo  output  1  emulated sensor echo pulse.

Function
REQ-016 Registers: addr 0 DIST (RW, cm, 16 b); addr 1 CTRL (RW, bit0 enable); addr 2 STATUS (RO: bit0 busy, bits[3:1] state, bits[15:8] valid-trigger count mod 256); addr 3 ERRCNT (RO, count of short triggers, saturates at 0xFFFF).
REQ-017 Write when cs&wr on a clk edge; writes to addr 2/3 ignored.
REQ-018 Read when cs&rd&!wr: d_out updated with addressed register one cycle later; otherwise d_out holds; cs&rd&wr performs write only.
REQ-019 trigg is synchronised through two flops before use; all trigg timing measured on the synchronised signal.
REQ-020 FSM states: IDLE, TRIG, BURST, ECHO, HOLD.
REQ-021 IDLE: on synchronised trigg rising with enable=1 -> TRIG, width counter cleared; enable=0 -> remain IDLE.
REQ-022 TRIG: counts high cycles; on fall with count >= T_TRIG_MIN -> BURST, latch DIST, increment trigger count; on fall with count < T_TRIG_MIN -> IDLE, increment ERRCNT.
REQ-023 TRIG width counter saturates; trigg held high indefinitely stays in TRIG.
REQ-024 BURST: after exactly T_BURST cycles -> ECHO, echo driven high on the transition edge.
REQ-025 Echo width = latched DIST*CYC_PER_CM cycles if 2 <= DIST <= 400, else T_TIMEOUT cycles; computed in >= 21-bit unsigned arithmetic, no truncation.
REQ-026 ECHO: after echo width cycles echo low -> HOLD.
REQ-027 HOLD: after T_HOLDOFF cycles -> IDLE; trigg activity in BURST, ECHO, HOLD ignored, not counted.
REQ-028 DIST/CTRL writes during a measurement affect only the next measurement; clearing enable mid-measurement does not abort it.
REQ-029 busy = 1 in any state other than IDLE.
REQ-030 echo is a direct register output, glitch-free.

Reset
REQ-031 rst=1: FSM -> IDLE, echo=0, d_out=0, DIST=0, CTRL=0 (disabled), trigger count=0, ERRCNT=0, all counters and sync flops cleared; effective next edge, including mid-ECHO.
REQ-032 First measurement after reset needs enable written to 1.

Verification
REQ-033 rst, write CTRL=1, DIST=35, trigg high 600 cycles -> echo rises T_BURST+2..3 cycles after trigg fall (sync latency), high exactly 101500 cycles.
REQ-034 DIST=500 and DIST=0, valid trigger -> echo high exactly 1900000 cycles each.
REQ-035 trigg high 100 cycles -> no echo, ERRCNT reads 1, trigger count unchanged.
REQ-036 Second trigger during ECHO and during HOLD -> ignored, echo width unchanged; trigger after HOLD -> new echo.
REQ-037 rst asserted mid-ECHO -> echo 0 next edge, STATUS reads 0, DIST reads 0.
REQ-038 Read addr 2 in ECHO with cs=1, rd=1 -> d_out bit0=1 one cycle later; rd&wr to addr 0 -> DIST written, d_out unchanged.
